// File: rtl/signed_muldiv_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
package signed_muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b1;
  localparam logic OP_DIV = 1'b0;

  // The iteration counter must be able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sm_conv.sv
// Two's-complement <-> sign/magnitude converter.
// The same conditional negation turns a signed value into its magnitude and
// turns a magnitude back into a signed value.
module sm_conv #(
  parameter int W = 4
) (
  input  logic [W-1:0] data,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~data + W'(1)) : data;

endmodule

// File: rtl/signed_muldiv_seq.sv
// Sequential signed multiplier (shift-add) and divider (restoring), one step
// per clock, working on magnitudes and fixing the sign at the end.
module signed_muldiv_seq
  import signed_muldiv_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sel,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         valid,
  output logic         error,
  output logic [N-1:0] m,
  output logic [N-1:0] r
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op;
  logic [N:0]    a_mag;
  logic [N:0]    b_mag;
  logic          res_neg;
  logic          rem_neg;
  logic          ovf;
  logic [2*N:0]  acc;

  logic [N:0]    a_mag_in;
  logic [N:0]    b_mag_in;
  logic [N+1:0]  mul_sum;
  logic [2*N:0]  mul_next;
  logic [N:0]    div_trial;
  logic          div_ge;
  logic [N:0]    div_rem;
  logic [2*N:0]  div_next;
  logic [2*N:0]  step_next;
  logic [2*N-1:0] prod_s;
  logic [N-1:0]  quo_s;
  logic [N-1:0]  rem_s;

  // Operand entry: N+1-bit magnitudes so that -2^(N-1) is representable.
  sm_conv #(.W(N+1)) u_conv_a (.data({A[N-1], A}), .negate(A[N-1]), .result(a_mag_in));
  sm_conv #(.W(N+1)) u_conv_b (.data({B[N-1], B}), .negate(B[N-1]), .result(b_mag_in));

  // Result exit: product and quotient take the combined sign, the remainder
  // takes the sign of the dividend.
  sm_conv #(.W(2*N)) u_conv_p (.data(step_next[2*N-1:0]), .negate(res_neg), .result(prod_s));
  sm_conv #(.W(N))   u_conv_q (.data(step_next[N-1:0]),   .negate(res_neg), .result(quo_s));
  sm_conv #(.W(N))   u_conv_r (.data(step_next[2*N-1:N]), .negate(rem_neg), .result(rem_s));

  // One iteration of either algorithm; acc holds {high/remainder, low/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*N:N]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_next  = {mul_sum, acc[N-1:1]};
    div_trial = {acc[2*N-1:N], acc[N-1]};
    div_ge    = (div_trial >= b_mag);
    div_rem   = div_ge ? (div_trial - b_mag) : div_trial;
    div_next  = {div_rem, acc[N-2:0], div_ge};
    step_next = (op == OP_MUL) ? mul_next : div_next;
  end

  // Control FSM with registered outputs; the final step and the result load
  // happen on the same edge so valid follows N steps after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= 1'b0;
      a_mag   <= '0;
      b_mag   <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      ovf     <= 1'b0;
      acc     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      error   <= 1'b0;
      m       <= '0;
      r       <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            op      <= sel;
            a_mag   <= a_mag_in;
            b_mag   <= b_mag_in;
            res_neg <= A[N-1] ^ B[N-1];
            rem_neg <= A[N-1];
            ovf     <= (sel == OP_DIV) && (A == MIN_VAL) && (B == '1);
            cnt     <= '0;
            acc     <= {{(N+1){1'b0}}, (sel == OP_MUL) ? b_mag_in[N-1:0] : a_mag_in[N-1:0]};
            if ((sel == OP_DIV) && (B == '0)) begin
              state <= DONE;
              valid <= 1'b1;
              error <= 1'b1;
              m     <= '1;
              r     <= A;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
            error <= ovf;
            if (op == OP_MUL) begin
              {m, r} <= prod_s;
            end else begin
              m <= quo_s;
              r <= rem_s;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_muldiv_seq.sv
// Directed self-checking bench for signed_muldiv_seq with N = 4.
module tb_signed_muldiv_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sel;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       valid;
  logic       error;
  logic [3:0] m;
  logic [3:0] r;

  int checks;
  int errors;

  signed_muldiv_seq #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .A(A), .B(B),
    .busy(busy), .valid(valid), .error(error), .m(m), .r(r)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request for one rising edge; returns 1ns after that edge.
  task automatic applyStimulus(input logic s, input logic [3:0] a, input logic [3:0] b);
    start = 1'b1;
    sel   = s;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges (accept edge = 1) until valid is seen, with a bound.
  task automatic waitValid(input int startLat, output int lat);
    lat = startLat;
    while (valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic s, input logic [3:0] a, input logic [3:0] b,
                       input int expLat, input logic [3:0] expM, input logic [3:0] expR,
                       input logic expErr);
    int lat;
    applyStimulus(s, a, b);
    waitValid(1, lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_m"}, 32'(m), 32'(expM));
    checkOutput({tag, "_r"}, 32'(r), 32'(expR));
    checkOutput({tag, "_err"}, 32'(error), 32'(expErr));
    @(posedge clk);
    #1;
    checkOutput({tag, "_validPulse"}, 32'(valid), 32'd0);
    checkOutput({tag, "_busyIdle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_mHold"}, 32'(m), 32'(expM));
    checkOutput({tag, "_rHold"}, 32'(r), 32'(expR));
  endtask

  initial begin
    int lat;
    int validSeen;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    sel    = 1'b0;
    A      = 4'h0;
    B      = 4'h0;

    // Reset state
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_m", 32'(m), 32'd0);
    checkOutput("rst_r", 32'(r), 32'd0);
    #10;
    rst_n = 1'b1;

    // Multiply: 5*2 = 10, -3*5 = -15, -8*-8 = 64
    runOp("mul_5x2", 1'b1, 4'h5, 4'h2, 5, 4'h0, 4'hA, 1'b0);
    runOp("mul_n3x5", 1'b1, 4'hD, 4'h5, 5, 4'hF, 4'h1, 1'b0);
    runOp("mul_n8xn8", 1'b1, 4'h8, 4'h8, 5, 4'h4, 4'h0, 1'b0);

    // Divide: 6/2 = 3 r0, -7/2 = -3 r-1, 7/-2 = -3 r1
    runOp("div_6d2", 1'b0, 4'h6, 4'h2, 5, 4'h3, 4'h0, 1'b0);
    runOp("div_n7d2", 1'b0, 4'h9, 4'h2, 5, 4'hD, 4'hF, 1'b0);
    runOp("div_7dn2", 1'b0, 4'h7, 4'hE, 5, 4'hD, 4'h1, 1'b0);

    // Divide exceptions: by zero (immediate) and -8/-1 overflow
    runOp("div_5d0", 1'b0, 4'h5, 4'h0, 1, 4'hF, 4'h5, 1'b1);
    runOp("div_n8dn1", 1'b0, 4'h8, 4'hF, 5, 4'h8, 4'h0, 1'b1);

    // Second start during CALC is ignored
    applyStimulus(1'b1, 4'h5, 4'h2);
    checkOutput("ign_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 4'hD, 4'h5);
    waitValid(3, lat);
    checkOutput("ign_lat", 32'(lat), 32'd5);
    checkOutput("ign_m", 32'(m), 32'h0);
    checkOutput("ign_r", 32'(r), 32'hA);
    @(posedge clk);
    #1;

    // Start in the DONE cycle is accepted back-to-back
    applyStimulus(1'b1, 4'h5, 4'h2);
    waitValid(1, lat);
    checkOutput("b2b_first_lat", 32'(lat), 32'd5);
    checkOutput("b2b_first_r", 32'(r), 32'hA);
    applyStimulus(1'b0, 4'h6, 4'h2);
    checkOutput("b2b_validLow", 32'(valid), 32'd0);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    waitValid(1, lat);
    checkOutput("b2b_second_lat", 32'(lat), 32'd5);
    checkOutput("b2b_second_m", 32'(m), 32'h3);
    checkOutput("b2b_second_r", 32'(r), 32'h0);
    @(posedge clk);
    #1;

    // Reset asserted in CALC cycle 2 aborts the operation
    applyStimulus(1'b1, 4'hD, 4'h5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(valid), 32'd0);
    checkOutput("abort_error", 32'(error), 32'd0);
    checkOutput("abort_m", 32'(m), 32'd0);
    checkOutput("abort_r", 32'(r), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    validSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 || busy === 1'b1) validSeen++;
    end
    checkOutput("abort_noValid", 32'(validSeen), 32'd0);

    // Fresh operation works after reset
    runOp("post_rst", 1'b1, 4'h3, 4'h3, 5, 4'h0, 4'h9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
